v_machine: RTL and testbench
============================

V_MACHINE -- requirements
Module: v_machine

Interface
REQ-001 SHALL have no parameters; all prices, stock limits and display mappings are fixed constants.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 rmb1  input  1  coin input; each rising edge adds 1 yuan.
REQ-005 keys  input  2  keys[0] rising edge adds 5 yuan, keys[1] rising edge adds 10 yuan.
REQ-006 keys2  input  1  refund; a rising edge returns all credit.
REQ-007 choice  input  8  item select, one-hot; choice[i] selects item i.
REQ-008 ok  input  1  purchase confirm; acts on its rising edge.
REQ-009 LED  output  56  eight 7-segment digits; HEXk = LED[7k+6:7k], bit 0 = seg a, bit 6 = seg g, active-low.
REQ-010 led  output  8  goods lamps; led[i] = 1 while item i is purchasable.

Function
REQ-011 SHALL register all control inputs and detect rising edges as (current & ~previous); each edge is one event.
REQ-012 SHALL hold credit (0-99), consumed (0-99) and change (0-99) as binary registers, decoded to BCD for display.
REQ-013 Item i price SHALL be i+1 yuan (item 0 = 1 ... item 7 = 8).
REQ-014 Coin events in the same cycle SHALL be summed; if credit + sum > 99, the whole sum SHALL be rejected and credit left unchanged.
REQ-015 The first accepted coin after a refund SHALL clear change to 0.
REQ-016 On ok edge with choice having exactly one bit set, credit >= price and the item purchasable: credit -= price, consumed += price (saturating at 99), stock of that item decremented.
REQ-017 ok edge with zero or multiple choice bits set, insufficient credit or an unavailable item SHALL change no state.
REQ-018 On keys2 edge: change = credit, credit = 0, consumed = 0.
REQ-019 Priority within a cycle: refund > purchase > coins; lower-priority edges in that cycle SHALL be discarded.
REQ-020 Display: HEX7:HEX6 = credit tens:units, HEX5:HEX4 = consumed, HEX1:HEX0 = change, HEX3 and HEX2 blank (all 1s); leading zeros shown.
REQ-021 Digit encoding (active-low, g..a): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-022 All state changes SHALL be visible on LED/led in the cycle after the edge-detect register sees the edge (2 clk after the input rises).

Reset
REQ-023 While rst is high: credit = consumed = change = 0, all edge-detect registers = 0, every stock counter = 7.
REQ-024 Reset out: LED = HEX7..4 and HEX1..0 showing 0 (1000000), HEX3..2 = 1111111; led = 8'hFF.
REQ-025 Reset SHALL override every event in the same cycle, including mid-transaction.

Configuration
REQ-026 Macro VMACHINE_STOCK_TRACK_EN defined: each item has a 3-bit stock counter (reset 7), an item is purchasable only while stock > 0, led[i] = (stock[i] != 0).
REQ-027 VMACHINE_STOCK_TRACK_EN undefined: no stock counters, every item is always purchasable, led[i] = choice[i].

Verification
REQ-028 Reset, then keys[1] edge, rmb1 edge -> credit 11, HEX7:HEX6 = "1","1", HEX5:HEX4 = "0","0".
REQ-029 Credit 11, choice = 8'h08, ok edge -> credit 7, consumed 4; repeat ok -> credit 3, consumed 8; a third ok -> no change.
REQ-030 Credit 3, keys2 edge -> credit 0, consumed 0, HEX1:HEX0 = "0","3"; next rmb1 edge -> change 0, credit 1.
REQ-031 Credit 95, keys[0] edge -> rejected, credit stays 95; rmb1 edge -> 96.
REQ-032 With VMACHINE_STOCK_TRACK_EN, credit 99, buy item 0 eight times -> first seven succeed, led[0] falls to 0 after seventh, eighth rejected, credit 92.
REQ-033 Same-cycle keys2, ok and rmb1 edges with credit 5 -> refund only: change 5, credit 0, no purchase, coin discarded.

Source files
------------

// File: rtl/v_machine_if.sv
// Bus bundle for the vending machine: coin, refund, selection and confirm
// inputs plus the seven-segment and goods-lamp outputs.
interface v_machine_if;
  logic        rmb1;
  logic [1:0]  keys;
  logic        keys2;
  logic [7:0]  choice;
  logic        ok;
  logic [55:0] LED;
  logic [7:0]  led;

  // Stimulus side: drives the panel inputs and watches the displays.
  modport master (
    output rmb1, keys, keys2, choice, ok,
    input  LED, led
  );

  // Machine side: samples the panel inputs and drives the displays.
  modport slave (
    input  rmb1, keys, keys2, choice, ok,
    output LED, led
  );
endinterface

// File: rtl/v_machine.sv
// Vending machine core: accepts 1/5/10 yuan coins, sells eight items priced
// 1..8 yuan, refunds on request, and shows credit, consumed and change on
// eight active-low seven-segment digits.
// Optional build macro: VMACHINE_STOCK_TRACK_EN adds a 3-bit stock counter per
// item; without it every item is always available and the lamps echo choice.
module v_machine (
  input  logic   clk,
  input  logic   rst,
  v_machine_if.slave bus
);

  localparam logic [6:0] MAX_MONEY = 7'd99;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Registered panel inputs and their one-cycle-older copies.
  logic       rmb1_cur,  rmb1_prev;
  logic [1:0] keys_cur,  keys_prev;
  logic       keys2_cur, keys2_prev;
  logic       ok_cur,    ok_prev;
  logic [7:0] choice_cur;

  // Rising-edge events, one cycle wide.
  logic       rmb1_edge;
  logic [1:0] keys_edge;
  logic       keys2_edge;
  logic       ok_edge;

  // Money registers, all binary 0..99.
  logic [6:0] credit,   credit_nxt;
  logic [6:0] consumed, consumed_nxt;
  logic [6:0] change,   change_nxt;

  // Purchase decode.
  logic [4:0] coin_sum;
  logic [7:0] credit_sum;
  logic [7:0] consumed_sum;
  logic [2:0] item_idx;
  logic [6:0] price;
  logic       one_hot;
  logic       item_ok;
  logic       buy;

  // Sample the panel inputs and keep the previous sample for edge detection.
  always_ff @(posedge clk) begin
    // NOTE: clocked state always uses non-blocking assignments so every
    // register sees the pre-edge value of its neighbours, as real flops do.
    if (rst) begin
      rmb1_cur   <= 1'b0;
      rmb1_prev  <= 1'b0;
      keys_cur   <= 2'b00;
      keys_prev  <= 2'b00;
      keys2_cur  <= 1'b0;
      keys2_prev <= 1'b0;
      ok_cur     <= 1'b0;
      ok_prev    <= 1'b0;
      choice_cur <= 8'h00;
    end else begin
      rmb1_cur   <= bus.rmb1;
      rmb1_prev  <= rmb1_cur;
      keys_cur   <= bus.keys;
      keys_prev  <= keys_cur;
      keys2_cur  <= bus.keys2;
      keys2_prev <= keys2_cur;
      ok_cur     <= bus.ok;
      ok_prev    <= ok_cur;
      choice_cur <= bus.choice;
    end
  end

  assign rmb1_edge  = rmb1_cur  & ~rmb1_prev;
  assign keys_edge  = keys_cur  & ~keys_prev;
  assign keys2_edge = keys2_cur & ~keys2_prev;
  assign ok_edge    = ok_cur    & ~ok_prev;

  // Decode the selection into an item index, its price and the coin total.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so
    // no path leaves it unassigned, which would otherwise infer a latch.
    item_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (choice_cur[i]) item_idx = 3'(i);
    end
    one_hot      = $onehot(choice_cur);
    price        = 7'({4'd0, item_idx}) + 7'd1;
    coin_sum     = {4'd0, rmb1_edge}
                 + (keys_edge[0] ? 5'd5  : 5'd0)
                 + (keys_edge[1] ? 5'd10 : 5'd0);
    credit_sum   = {1'b0, credit}   + {3'd0, coin_sum};
    consumed_sum = {1'b0, consumed} + {1'b0, price};
  end

`ifdef VMACHINE_STOCK_TRACK_EN
  logic [2:0] stock [8];

  // Per-item stock: full on reset, one less for every completed sale.
  always_ff @(posedge clk) begin
    // NOTE: the stock array is small and must start full, so each entry is
    // reset explicitly rather than left to power-up contents.
    if (rst) begin
      for (int i = 0; i < 8; i++) stock[i] <= 3'd7;
    end else if (buy) begin
      stock[item_idx] <= stock[item_idx] - 3'd1;
    end
  end

  assign item_ok = (stock[item_idx] != 3'd0);

  // Goods lamps follow remaining stock.
  always_comb begin
    for (int i = 0; i < 8; i++) bus.led[i] = (stock[i] != 3'd0);
  end
`else
  assign item_ok = 1'b1;
  assign bus.led = bus.choice;
`endif

  // Resolve one event per cycle: refund beats purchase beats coins.
  always_comb begin
    credit_nxt   = credit;
    consumed_nxt = consumed;
    change_nxt   = change;
    buy          = 1'b0;
    if (keys2_edge) begin
      change_nxt   = credit;
      credit_nxt   = 7'd0;
      consumed_nxt = 7'd0;
    end else if (ok_edge) begin
      // An ok edge claims the cycle even when the sale is refused.
      if (one_hot && item_ok && (credit >= price)) begin
        buy          = 1'b1;
        credit_nxt   = credit - price;
        consumed_nxt = (consumed_sum > {1'b0, MAX_MONEY}) ? MAX_MONEY
                                                         : consumed_sum[6:0];
      end
    end else if ((coin_sum != 5'd0) && (credit_sum <= {1'b0, MAX_MONEY})) begin
      // Change is only ever loaded by a refund, so clearing it on every
      // accepted coin clears it on the first coin after that refund.
      credit_nxt = credit_sum[6:0];
      change_nxt = 7'd0;
    end
  end

  // Money registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      credit   <= 7'd0;
      consumed <= 7'd0;
      change   <= 7'd0;
    end else begin
      credit   <= credit_nxt;
      consumed <= consumed_nxt;
      change   <= change_nxt;
    end
  end

  // Active-low segment pattern (g..a) for one decimal digit.
  function automatic logic [6:0] seg7(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // Two-digit display (tens, units) of a 0..99 binary value.
  function automatic logic [13:0] show2(input logic [6:0] value);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = 4'(value / 7'd10);
    units = 4'(value % 7'd10);
    return {seg7(tens), seg7(units)};
  endfunction

  // Drive the eight digits: credit, consumed, two blanks, change.
  always_comb begin
    bus.LED = {show2(credit), show2(consumed), SEG_BLANK, SEG_BLANK, show2(change)};
  end

endmodule

// File: tb/tb_v_machine.sv
// Directed bench for v_machine: coin entry, purchases, refunds, overflow
// rejection, event priority, reset override and (with
// VMACHINE_STOCK_TRACK_EN) stock exhaustion.
module tb_v_machine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  v_machine_if bus ();

  v_machine dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Digit patterns 0..9 straight from the display table.
  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  function automatic logic [55:0] exp_led(input int cr, input int co, input int ch);
    return {seg_tab[cr / 10], seg_tab[cr % 10], seg_tab[co / 10], seg_tab[co % 10],
            7'h7F, 7'h7F, seg_tab[ch / 10], seg_tab[ch % 10]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_disp(input string tag, input int cr, input int co, input int ch);
    check(tag, {8'd0, bus.LED}, {8'd0, exp_led(cr, co, ch)});
  endtask

  // One input pulse, then wait until the result is on the displays.
  task automatic pulse(input logic r, input logic [1:0] k, input logic k2, input logic o);
    @(negedge clk);
    bus.rmb1 = r; bus.keys = k; bus.keys2 = k2; bus.ok = o;
    @(negedge clk);
    bus.rmb1 = 1'b0; bus.keys = 2'b00; bus.keys2 = 1'b0; bus.ok = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    bus.rmb1 = 1'b0; bus.keys = 2'b00; bus.keys2 = 1'b0; bus.ok = 1'b0;
    bus.choice = 8'h00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_disp("reset_led", 0, 0, 0);
`ifdef VMACHINE_STOCK_TRACK_EN
    check("reset_lamps", {56'd0, bus.led}, 64'hFF);
`else
    check("reset_lamps", {56'd0, bus.led}, 64'h00);
`endif
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Ten then one yuan.
    pulse(1'b0, 2'b10, 1'b0, 1'b0);
    check_disp("coin10", 10, 0, 0);
    pulse(1'b1, 2'b00, 1'b0, 1'b0);
    check_disp("coin1_credit11", 11, 0, 0);

    // Item 3 costs 4: two sales, third refused for lack of credit.
    bus.choice = 8'h08;
    pulse(1'b0, 2'b00, 1'b0, 1'b1);
    check_disp("buy1_item3", 7, 4, 0);
`ifndef VMACHINE_STOCK_TRACK_EN
    check("lamps_follow_choice", {56'd0, bus.led}, 64'h08);
`endif
    pulse(1'b0, 2'b00, 1'b0, 1'b1);
    check_disp("buy2_item3", 3, 8, 0);
    pulse(1'b0, 2'b00, 1'b0, 1'b1);
    check_disp("buy3_insufficient", 3, 8, 0);

    // Refund, then the next coin clears the change.
    pulse(1'b0, 2'b00, 1'b1, 1'b0);
    check_disp("refund3", 0, 0, 3);
    pulse(1'b1, 2'b00, 1'b0, 1'b0);
    check_disp("coin_clears_change", 1, 0, 0);

    // Three coins in one cycle sum to 16.
    pulse(1'b1, 2'b11, 1'b0, 1'b0);
    check_disp("coin_sum16", 17, 0, 0);
    repeat (7) pulse(1'b0, 2'b10, 1'b0, 1'b0);
    pulse(1'b0, 2'b01, 1'b0, 1'b0);
    repeat (3) pulse(1'b1, 2'b00, 1'b0, 1'b0);
    check_disp("credit95", 95, 0, 0);
    pulse(1'b0, 2'b01, 1'b0, 1'b0);
    check_disp("reject_overflow5", 95, 0, 0);
    pulse(1'b1, 2'b00, 1'b0, 1'b0);
    check_disp("credit96", 96, 0, 0);
    pulse(1'b1, 2'b11, 1'b0, 1'b0);
    check_disp("reject_sum16", 96, 0, 0);
    repeat (3) pulse(1'b1, 2'b00, 1'b0, 1'b0);
    check_disp("credit99", 99, 0, 0);
    pulse(1'b1, 2'b00, 1'b0, 1'b0);
    check_disp("reject_at99", 99, 0, 0);

    // Bad selections change nothing.
    bus.choice = 8'h03;
    pulse(1'b0, 2'b00, 1'b0, 1'b1);
    check_disp("multi_choice", 99, 0, 0);
    bus.choice = 8'h00;
    pulse(1'b0, 2'b00, 1'b0, 1'b1);
    check_disp("no_choice", 99, 0, 0);

    // Run consumed up to its ceiling.
    bus.choice = 8'h80;
    repeat (5) pulse(1'b0, 2'b00, 1'b0, 1'b1);
    check_disp("buy_item7_x5", 59, 40, 0);
    bus.choice = 8'h40;
    repeat (5) pulse(1'b0, 2'b00, 1'b0, 1'b1);
    check_disp("buy_item6_x5", 24, 75, 0);
    bus.choice = 8'h20;
    repeat (3) pulse(1'b0, 2'b00, 1'b0, 1'b1);
    check_disp("buy_item5_x3", 6, 93, 0);
    pulse(1'b0, 2'b10, 1'b0, 1'b0);
    bus.choice = 8'h80;
    pulse(1'b0, 2'b00, 1'b0, 1'b1);
    check_disp("consumed_saturates", 8, 99, 0);
    pulse(1'b0, 2'b00, 1'b0, 1'b1);
    check_disp("exact_credit", 0, 99, 0);
    bus.choice = 8'h01;
    pulse(1'b0, 2'b00, 1'b0, 1'b1);
    check_disp("zero_credit", 0, 99, 0);

    // Same-cycle refund, purchase and coin: only the refund acts.
    pulse(1'b0, 2'b01, 1'b0, 1'b0);
    check_disp("credit5", 5, 99, 0);
    pulse(1'b1, 2'b00, 1'b1, 1'b1);
    check_disp("refund_priority", 0, 0, 5);

    // Purchase beats a same-cycle coin.
    pulse(1'b1, 2'b00, 1'b0, 1'b0);
    pulse(1'b0, 2'b10, 1'b0, 1'b1);
    check_disp("buy_over_coin", 0, 1, 0);

    // Reset in the middle of a coin event wipes everything.
    pulse(1'b1, 2'b00, 1'b0, 1'b0);
    check_disp("pre_reset", 1, 1, 0);
    @(negedge clk);
    rst = 1'b1; bus.keys = 2'b10;
    repeat (2) @(negedge clk);
    bus.keys = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_disp("reset_mid_event", 0, 0, 0);

`ifdef VMACHINE_STOCK_TRACK_EN
    // Seven units of item 0, the eighth is refused.
    repeat (9) pulse(1'b0, 2'b10, 1'b0, 1'b0);
    repeat (9) pulse(1'b1, 2'b00, 1'b0, 1'b0);
    check_disp("stock_credit99", 99, 0, 0);
    bus.choice = 8'h01;
    repeat (7) pulse(1'b0, 2'b00, 1'b0, 1'b1);
    check_disp("stock_seven_sold", 92, 7, 0);
    check("stock_lamp0_off", {56'd0, bus.led}, 64'hFE);
    pulse(1'b0, 2'b00, 1'b0, 1'b1);
    check_disp("stock_eighth_refused", 92, 7, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
